// File: rtl/seq_divider.sv
// seq_divider: multi-cycle unsigned restoring divider, one quotient bit per clock.
// Single-cycle start/done handshake; a zero divisor short-circuits straight to DONE.
module seq_divider #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [WIDTH:0]   r_q, r_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] d_q, d_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             dbz_q, dbz_d;

   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   trial;

   // The partial remainder always stays below the divisor, so its top bit is never consumed.
   logic             unused_r_msb;
   assign unused_r_msb = r_q[WIDTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         r_q     <= '0;
         q_q     <= '0;
         d_q     <= '0;
         cnt_q   <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         r_q     <= r_d;
         q_q     <= q_d;
         d_q     <= d_d;
         cnt_q   <= cnt_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         dbz_q   <= dbz_d;
      end
   end

   always_comb begin
      state_d = state_q;
      r_d     = r_q;
      q_d     = q_q;
      d_d     = d_q;
      cnt_d   = cnt_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      dbz_d   = dbz_q;

      // Trial subtraction: shift next dividend bit in, subtract divisor, MSB is the borrow.
      shifted = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
      trial   = shifted - {1'b0, d_q};

      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (divisor != '0) begin
                  q_d     = dividend;
                  d_d     = divisor;
                  r_d     = '0;
                  cnt_d   = CW'(WIDTH);
                  dbz_d   = 1'b0;
                  state_d = S_CALC;
               end else begin
                  quo_d   = '1;
                  rem_d   = dividend;
                  dbz_d   = 1'b1;
                  state_d = S_DONE;
               end
            end
         end
         S_CALC: begin
            if (!trial[WIDTH]) begin
               r_d = trial;
               q_d = {q_q[WIDTH-2:0], 1'b1};
            end else begin
               r_d = shifted;
               q_d = {q_q[WIDTH-2:0], 1'b0};
            end
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               quo_d   = q_d;
               rem_d   = r_d[WIDTH-1:0];
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_DONE);
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign quotient    = quo_q;
   assign remainder   = rem_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: a 4-bit and an 8-bit instance checked
// against a reference divide model through per-instance scoreboard queues.
module tb_seq_divider;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       start4, busy4, done4, dbz4;
   logic [3:0] dvd4, dvs4, quo4, rem4;
   logic       start8, busy8, done8, dbz8;
   logic [7:0] dvd8, dvs8, quo8, rem8;

   typedef struct packed {
      logic [7:0] q;
      logic [7:0] r;
      logic       dbz;
   } exp_t;

   exp_t sb4[$];
   exp_t sb8[$];
   int   n_cmp = 0;
   int   n_err = 0;

   seq_divider #(.WIDTH(4)) dut4 (
      .clk(clk), .rst(rst), .start(start4), .dividend(dvd4), .divisor(dvs4),
      .busy(busy4), .done(done4), .quotient(quo4), .remainder(rem4), .div_by_zero(dbz4)
   );

   seq_divider #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .dividend(dvd8), .divisor(dvs8),
      .busy(busy8), .done(done8), .quotient(quo8), .remainder(rem8), .div_by_zero(dbz8)
   );

   function automatic exp_t model(input int w, input logic [7:0] a, input logic [7:0] b);
      exp_t e;
      if (b == 8'd0) begin
         e.q   = (w == 4) ? 8'h0F : 8'hFF;
         e.r   = a;
         e.dbz = 1'b1;
      end else begin
         e.q   = a / b;
         e.r   = a % b;
         e.dbz = 1'b0;
      end
      return e;
   endfunction

   // Start pulse for one instance; returns at the falling edge after the sampling edge.
   task automatic pulse(input bit w8, input logic [7:0] a, input logic [7:0] b);
      @(negedge clk);
      if (w8) begin
         start8 = 1'b1; dvd8 = a; dvs8 = b;
         sb8.push_back(model(8, a, b));
      end else begin
         start4 = 1'b1; dvd4 = a[3:0]; dvs4 = b[3:0];
         sb4.push_back(model(4, a, b));
      end
      @(negedge clk);
      start4 = 1'b0;
      start8 = 1'b0;
   endtask

   // Bounded wait for done; lat counts rising edges after the start-sampling edge.
   task automatic wait_done(input bit w8, output int lat);
      lat = 0;
      while (!(w8 ? done8 : done4) && lat < 40) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      start4 = 1'b0; dvd4 = '0; dvs4 = '0;
      start8 = 1'b0; dvd8 = '0; dvs8 = '0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({busy4, done4, quo4, rem4, dbz4} !== 11'd0) begin
         n_err++;
         $display("FAIL reset4: got busy=%b done=%b q=%0d r=%0d dbz=%b, want all 0", busy4, done4, quo4, rem4, dbz4);
      end
      n_cmp++;
      if ({busy8, done8, quo8, rem8, dbz8} !== 19'd0) begin
         n_err++;
         $display("FAIL reset8: got busy=%b done=%b q=%0d r=%0d dbz=%b, want all 0", busy8, done8, quo8, rem8, dbz8);
      end
      rst = 1'b0;
   endtask

   task automatic test_basic;
      int nbusy = 0, ndone = 0, dlat = -1;
      logic [3:0] gq = '0, gr = '0;
      logic gz = 1'b0;
      exp_t e;
      pulse(0, 8'd13, 8'd3);
      for (int k = 0; k < 9; k++) begin
         if (k > 0) @(negedge clk);
         if (busy4) nbusy++;
         if (done4) begin ndone++; dlat = k; gq = quo4; gr = rem4; gz = dbz4; end
      end
      e = sb4.pop_front();
      n_cmp++;
      if ({gq, gr, gz} !== {e.q[3:0], e.r[3:0], e.dbz}) begin
         n_err++;
         $display("FAIL basic_13_3: got q=%0d r=%0d dbz=%b, want q=%0d r=%0d dbz=%b", gq, gr, gz, e.q, e.r, e.dbz);
      end
      n_cmp++;
      if (ndone !== 1 || dlat !== 4) begin
         n_err++;
         $display("FAIL basic_done: got %0d pulses at edge %0d, want 1 at edge 4", ndone, dlat);
      end
      n_cmp++;
      if (nbusy !== 5) begin
         n_err++;
         $display("FAIL basic_busy: got %0d busy cycles, want 5", nbusy);
      end
   endtask

   task automatic test_boundary;
      logic [7:0] ta[5] = '{8'd15, 8'd2, 8'd0, 8'd15, 8'd13};
      logic [7:0] tb[5] = '{8'd1, 8'd7, 8'd5, 8'd15, 8'd1};
      int lat;
      exp_t e;
      for (int i = 0; i < 5; i++) begin
         pulse(0, ta[i], tb[i]);
         wait_done(0, lat);
         e = sb4.pop_front();
         n_cmp++;
         if ({quo4, rem4, dbz4} !== {e.q[3:0], e.r[3:0], e.dbz} || lat !== 4) begin
            n_err++;
            $display("FAIL boundary %0d/%0d: got q=%0d r=%0d dbz=%b lat=%0d, want q=%0d r=%0d dbz=%b lat=4",
                     ta[i], tb[i], quo4, rem4, dbz4, lat, e.q, e.r, e.dbz);
         end
      end
   endtask

   task automatic test_div_zero;
      int lat;
      exp_t e;
      pulse(0, 8'd9, 8'd0);
      wait_done(0, lat);
      e = sb4.pop_front();
      n_cmp++;
      if ({quo4, rem4, dbz4} !== {4'd15, 4'd9, 1'b1} || {quo4, rem4, dbz4} !== {e.q[3:0], e.r[3:0], e.dbz} || lat !== 0) begin
         n_err++;
         $display("FAIL div_zero_9_0: got q=%0d r=%0d dbz=%b lat=%0d, want q=15 r=9 dbz=1 lat=0", quo4, rem4, dbz4, lat);
      end
      pulse(0, 8'd8, 8'd2);
      wait_done(0, lat);
      e = sb4.pop_front();
      n_cmp++;
      if ({quo4, rem4, dbz4} !== {e.q[3:0], e.r[3:0], e.dbz} || lat !== 4) begin
         n_err++;
         $display("FAIL after_zero_8_2: got q=%0d r=%0d dbz=%b lat=%0d, want q=%0d r=%0d dbz=%b lat=4",
                  quo4, rem4, dbz4, lat, e.q, e.r, e.dbz);
      end
   endtask

   task automatic test_ignore_start;
      int ndone = 0, dlat = -1;
      logic [3:0] gq = '0, gr = '0;
      logic gz = 1'b1;
      exp_t e;
      pulse(0, 8'd13, 8'd3);
      // Starts sampled on CALC edges 2..4 and on the DONE edge 5 must all be dropped.
      for (int k = 1; k <= 9; k++) begin
         @(negedge clk);
         if (done4) begin ndone++; dlat = k; gq = quo4; gr = rem4; gz = dbz4; end
         start4 = (k <= 4);
         dvd4   = 4'd14;
         dvs4   = 4'd5;
      end
      start4 = 1'b0;
      e = sb4.pop_front();
      n_cmp++;
      if ({gq, gr, gz} !== {e.q[3:0], e.r[3:0], e.dbz} || ndone !== 1 || dlat !== 4) begin
         n_err++;
         $display("FAIL ignore_start: got q=%0d r=%0d dbz=%b done_count=%0d at edge %0d, want q=%0d r=%0d dbz=%b 1 at edge 4",
                  gq, gr, gz, ndone, dlat, e.q, e.r, e.dbz);
      end
      n_cmp++;
      if (busy4 !== 1'b0) begin
         n_err++;
         $display("FAIL ignore_idle: got busy=%b after drop, want 0", busy4);
      end
   endtask

   task automatic test_reset_mid;
      int ndone = 0, lat;
      exp_t e;
      pulse(0, 8'd13, 8'd3);
      e = sb4.pop_back();
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      n_cmp++;
      if ({busy4, done4, quo4, rem4, dbz4} !== 11'd0) begin
         n_err++;
         $display("FAIL reset_mid: got busy=%b done=%b q=%0d r=%0d dbz=%b, want all 0", busy4, done4, quo4, rem4, dbz4);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (done4) ndone++;
      end
      n_cmp++;
      if (ndone !== 0) begin
         n_err++;
         $display("FAIL reset_no_done: got %0d done pulses, want 0", ndone);
      end
      pulse(0, 8'd7, 8'd2);
      wait_done(0, lat);
      e = sb4.pop_front();
      n_cmp++;
      if ({quo4, rem4, dbz4} !== {4'd3, 4'd1, 1'b0} || {quo4, rem4, dbz4} !== {e.q[3:0], e.r[3:0], e.dbz} || lat !== 4) begin
         n_err++;
         $display("FAIL after_reset_7_2: got q=%0d r=%0d dbz=%b lat=%0d, want q=3 r=1 dbz=0 lat=4", quo4, rem4, dbz4, lat);
      end
   endtask

   // Back-to-back exhaustive sweep: each start lands in the IDLE cycle right after DONE.
   task automatic test_sweep4;
      int lat, bad = 0;
      exp_t e;
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            pulse(0, 8'(a), 8'(b));
            wait_done(0, lat);
            e = sb4.pop_front();
            n_cmp++;
            if ({quo4, rem4, dbz4} !== {e.q[3:0], e.r[3:0], e.dbz} || lat !== ((b == 0) ? 0 : 4)) begin
               n_err++;
               bad++;
               if (bad <= 10)
                  $display("FAIL sweep4 %0d/%0d: got q=%0d r=%0d dbz=%b lat=%0d, want q=%0d r=%0d dbz=%b lat=%0d",
                           a, b, quo4, rem4, dbz4, lat, e.q, e.r, e.dbz, (b == 0) ? 0 : 4);
            end
         end
      end
   endtask

   task automatic test_random8;
      int lat, bad = 0;
      logic [7:0] a, b;
      exp_t e;
      for (int i = 0; i < 60; i++) begin
         a = 8'($urandom_range(0, 255));
         b = (i % 10 == 0) ? 8'd0 : 8'($urandom_range(0, 255));
         if (i == 1) begin a = 8'd255; b = 8'd1; end
         if (i == 2) begin a = 8'd255; b = 8'd255; end
         pulse(1, a, b);
         wait_done(1, lat);
         e = sb8.pop_front();
         n_cmp++;
         if ({quo8, rem8, dbz8} !== {e.q, e.r, e.dbz} || lat !== ((b == 0) ? 0 : 8)) begin
            n_err++;
            bad++;
            if (bad <= 10)
               $display("FAIL random8 %0d/%0d: got q=%0d r=%0d dbz=%b lat=%0d, want q=%0d r=%0d dbz=%b lat=%0d",
                        a, b, quo8, rem8, dbz8, lat, e.q, e.r, e.dbz, (b == 0) ? 0 : 8);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_boundary();
      test_div_zero();
      test_ignore_start();
      test_reset_mid();
      test_sweep4();
      test_random8();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/seq_divider.md
# seq_divider

Multi-cycle unsigned restoring divider. It is the inverse-operation companion to the team's adder/subtractor datapath. Each iteration performs one trial subtraction with borrow detection, exactly as the add/sub unit does in subtract mode (m=1), and produces one quotient bit per clock. It sits beside the add/sub block in the arithmetic unit and is driven by a single-cycle start / done handshake.

## Interface
- WIDTH, 4, operand, quotient and remainder width in bits (legal range 2–16)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request pulse; sampled only in IDLE
- dividend  input  WIDTH  unsigned dividend, sampled with start
- divisor  input  WIDTH  unsigned divisor, sampled with start
- busy  output  1  high in CALC and DONE
- done  output  1  single-cycle pulse; results valid on this cycle
- quotient  output  WIDTH  unsigned quotient, held until next accepted start
- remainder  output  WIDTH  unsigned remainder, held until next accepted start
- div_by_zero  output  1  flags that the last accepted operation had divisor == 0, held with the results

## Operation
- States: IDLE, CALC, DONE. State encoding is free.
- Internal registers:
  - R: partial remainder, WIDTH+1 bits
  - Q: WIDTH bits; holds the dividend and shifts into the quotient
  - D: latched divisor, WIDTH bits
  - cnt: iteration counter, clog2(WIDTH+1) bits
- IDLE, start=1, divisor≠0:
  - latch Q←dividend, D←divisor, R←0, cnt←WIDTH
  - clear div_by_zero
  - go to CALC
- IDLE, start=1, divisor=0:
  - quotient←all ones, remainder←dividend, div_by_zero←1
  - go to DONE; no CALC cycles are spent
- CALC, each cycle:
  - compute T = {R[WIDTH-1:0], Q[WIDTH-1]} − {1'b0, D} at WIDTH+1 bits
  - no borrow (T[WIDTH]=0): R←T, Q←{Q[WIDTH-2:0],1}
  - borrow: R←{R[WIDTH-1:0], Q[WIDTH-1]}, Q←{Q[WIDTH-2:0],0}
  - cnt←cnt−1
  - on the iteration where cnt==1, go to DONE and load quotient←final Q and remainder←final R[WIDTH-1:0]
- DONE: done=1 for exactly one cycle, then IDLE unconditionally.
- start is ignored in CALC and DONE. No queuing; a start in DONE is dropped.
- quotient, remainder and div_by_zero change only on the transition into DONE. They hold between operations.
- Invariant for non-zero divisor: dividend == quotient·divisor + remainder, and remainder < divisor.
- rst (any time, including mid-CALC):
  - state→IDLE
  - busy, done, div_by_zero, quotient, remainder, R, Q, D, cnt all →0
  - the aborted operation produces no done

## Timing
- Cycle 0 is the rising edge that samples start=1 in IDLE.
- Normal latency: busy rises after edge 0; CALC occupies edges 1..WIDTH; done is high for the cycle following edge WIDTH. With WIDTH=4, done is seen after edge 4, and busy falls after edge WIDTH+1.
- Divide-by-zero latency: done is high for the cycle following edge 0.
- Back-to-back throughput: one operation per WIDTH+2 cycles (the earliest new start is in the IDLE cycle after DONE).
- done and busy are registered outputs, not combinational from start.
- Reset values: busy=0, done=0, quotient=0, remainder=0, div_by_zero=0.

## Test plan
- WIDTH=4, dividend=13, divisor=3, start one cycle -> quotient=4, remainder=1, div_by_zero=0, done high for exactly one cycle 4 edges after start, busy high for 5 cycles.
- Boundary operands:
  - 15/1 -> Q=15, R=0
  - 2/7 -> Q=0, R=2
  - 0/5 -> Q=0, R=0
  - 15/15 -> Q=1, R=0
- 9/0 -> done on the cycle after start, quotient=15, remainder=9, div_by_zero=1. A following 8/2 clears the flag, with Q=4, R=0.
- Start pulses during CALC and during DONE with different operands -> ignored; results match the first operation only and exactly one done is produced.
- Assert rst for one cycle after CALC edge 2 of 13/3 -> all outputs 0 asynchronously, no done afterwards. A fresh 7/2 then yields Q=3, R=1.
- Exhaustive sweep of all 256 operand pairs at WIDTH=4 plus random pairs at WIDTH=8 -> every result satisfies the invariant or the divide-by-zero rule, with fixed latency.
